mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter: DEPTH_WORDS, 256, number of 32-bit words in backing store (power of two, 16..4096).
REQ-002 SHALL have parameter: LATENCY, 3, cycles from request acceptance to mem_resp (1..15).
REQ-003 SHALL have one clock and a reset: clk and rst; rst is asynchronous and active-high.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: mem_read  input  1  read request from initiator.
REQ-007 SHALL have port: mem_write  input  1  write request from initiator.
REQ-008 SHALL have port: mem_byte_enable  input  4  per-byte write mask; bit i enables mem_wdata[8i+7:8i].
REQ-009 SHALL have port: mem_address  input  32  byte address.
REQ-010 SHALL have port: mem_wdata  input  32  write data.
REQ-011 SHALL have port: mem_rdata  output  32  read data, valid when mem_resp=1 on a read.
REQ-012 SHALL have port: mem_resp  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: busy  output  1  high while a transaction is in flight (state != IDLE).
REQ-014 SHALL have port: addr_err  output  1  pulses with mem_resp when the latched address is out of range.
REQ-015 SHALL have port: protocol_err  output  1  sticky; set when mem_read and mem_write are both high in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 In IDLE with exactly one of mem_read/mem_write high, SHALL latch op, address, wdata and byte_enable, then go to WAIT (LATENCY>1) or RESP (LATENCY=1), loading down-counter with LATENCY-2.
REQ-018 WAIT SHALL decrement counter each cycle and go to RESP on the cycle counter=0.
REQ-019 RESP SHALL assert mem_resp for exactly one cycle, then return to IDLE.
REQ-020 Request seen in IDLE at cycle N SHALL produce mem_resp at cycle N+LATENCY.
REQ-021 A new request SHALL be accepted in the IDLE cycle immediately after RESP (back-to-back throughput: one transaction per LATENCY+1 cycles).
REQ-022 Input changes or request deassertion during WAIT/RESP SHALL be ignored; the latched transaction completes.
REQ-023 Word index = latched address[log2(DEPTH_WORDS)+1:2]; address[1:0] ignored.
REQ-024 Address >= 4*DEPTH_WORDS SHALL be out of range: write suppressed, mem_rdata = 0, mem_resp still given, addr_err=1 in the RESP cycle.
REQ-025 Write SHALL commit on the edge entering RESP, updating only enabled bytes; byte_enable=0000 writes nothing.
REQ-026 Read data SHALL be registered on the edge entering RESP and held on mem_rdata until the next read completes.
REQ-027 A write followed immediately by a read of the same address SHALL return the written data.
REQ-028 Both mem_read and mem_write high in IDLE SHALL be rejected: no state change, no mem_resp, protocol_err set.

Reset
REQ-029 rst SHALL force IDLE, mem_resp=0, busy=0, addr_err=0, protocol_err=0, mem_rdata=0, counter=0, immediately without waiting for clk.
REQ-030 rst mid-transaction SHALL abort it: no mem_resp, pending write not committed.
REQ-031 Backing store contents SHALL NOT be cleared by reset.

Verification
REQ-032 LATENCY=3: write 0xDEADBEEF to 0x40 (be=1111) at cycle 0 -> mem_resp at cycle 3 only; read 0x40 -> mem_rdata=0xDEADBEEF with mem_resp.
REQ-033 After REQ-032, write 0x000000AA to 0x40 with be=0001, read back -> 0xDEADBEAA.
REQ-034 DEPTH_WORDS=256, read 0x400 -> mem_resp with addr_err=1, mem_rdata=0; prior contents unchanged.
REQ-035 mem_read and mem_write both high for 2 cycles -> no mem_resp, busy=0, protocol_err=1 until rst.
REQ-036 Assert rst one cycle after write acceptance to 0x80 (prior value 0x11111111) -> no mem_resp; later read 0x80 returns 0x11111111.
REQ-037 LATENCY=1 back-to-back reads of 0x0 and 0x4 held high -> mem_resp at cycles 1 and 3, correct data each.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one transaction at a time, byte-masked writes,
// out-of-range detection and a sticky protocol error for conflicting requests.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        busy,
  output logic        addr_err,
  output logic        protocol_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [3:0]      cnt_r;
  logic [3:0]      cnt_next_s;
  logic            accept_s;
  logic            conflict_s;
  logic            enter_resp_s;

  logic            op_write_r;
  logic [AW-1:0]   idx_r;
  logic            oor_r;
  logic [31:0]     wdata_r;
  logic [3:0]      be_r;

  logic            cur_write_s;
  logic [AW-1:0]   cur_idx_s;
  logic            cur_oor_s;
  logic [31:0]     cur_wdata_s;
  logic [3:0]      cur_be_s;
  logic            mem_we_s;
  logic            unused_addr_s;

  logic [31:0]     mem_r [DEPTH_WORDS];

  assign unused_addr_s = ^mem_address[1:0];

  // Next-state, countdown and acceptance decode
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    conflict_s   = 1'b0;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_read ^ mem_write) begin
          accept_s   = 1'b1;
          cnt_next_s = CNT_LOAD;
          if (LATENCY > 1) begin
            state_next_s = WAIT;
          end else begin
            state_next_s = RESP;
            enter_resp_s = 1'b1;
          end
        end else if (mem_read && mem_write) begin
          conflict_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // With LATENCY=1 the RESP edge is also the accept edge, so bypass the latches
  always_comb begin
    if (accept_s) begin
      cur_write_s = mem_write;
      cur_idx_s   = mem_address[AW+1:2];
      cur_oor_s   = |mem_address[31:AW+2];
      cur_wdata_s = mem_wdata;
      cur_be_s    = mem_byte_enable;
    end else begin
      cur_write_s = op_write_r;
      cur_idx_s   = idx_r;
      cur_oor_s   = oor_r;
      cur_wdata_s = wdata_r;
      cur_be_s    = be_r;
    end
    mem_we_s = enter_resp_s && cur_write_s && !cur_oor_s && !rst;
  end

  // Control state and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      mem_resp     <= 1'b0;
      busy         <= 1'b0;
      addr_err     <= 1'b0;
      protocol_err <= 1'b0;
      mem_rdata    <= 32'd0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      mem_resp     <= enter_resp_s;
      busy         <= (state_next_s != IDLE);
      addr_err     <= enter_resp_s && cur_oor_s;
      protocol_err <= protocol_err || conflict_s;
      if (enter_resp_s && !cur_write_s) begin
        mem_rdata <= cur_oor_s ? 32'd0 : mem_r[cur_idx_s];
      end
    end
  end

  // Latched transaction fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_write_r <= 1'b0;
      idx_r      <= '0;
      oor_r      <= 1'b0;
      wdata_r    <= 32'd0;
      be_r       <= 4'd0;
    end else if (accept_s) begin
      op_write_r <= mem_write;
      idx_r      <= mem_address[AW+1:2];
      oor_r      <= |mem_address[31:AW+2];
      wdata_r    <= mem_wdata;
      be_r       <= mem_byte_enable;
    end
  end

  // Backing store survives reset; bytes commit on the edge entering RESP
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be_s[i]) begin
          mem_r[cur_idx_s][8*i +: 8] <= cur_wdata_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and random checks of mem_responder (LATENCY 3 and 1) against a
// word-array reference model with byte masking and range rules.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd    [2];
  logic        wr    [2];
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        resp  [2];
  logic        busy  [2];
  logic        aerr  [2];
  logic        perr  [2];

  int          lat   [2] = '{3, 1};
  int          depth [2] = '{256, 64};
  logic [31:0] model [2][256];
  logic [31:0] last_rd [2];
  int          n_asrt = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u0 (
    .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_byte_enable(be[0]), .mem_address(addr[0]), .mem_wdata(wdata[0]),
    .mem_rdata(rdata[0]), .mem_resp(resp[0]), .busy(busy[0]),
    .addr_err(aerr[0]), .protocol_err(perr[0]));

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_byte_enable(be[1]), .mem_address(addr[1]), .mem_wdata(wdata[1]),
    .mem_rdata(rdata[1]), .mem_resp(resp[1]), .busy(busy[1]),
    .addr_err(aerr[1]), .protocol_err(perr[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: present for one edge, then scramble inputs while in flight
  task automatic txn(input int k, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    bit inr;
    int wi;
    inr = (a < 32'(4 * depth[k]));
    wi  = int'(a >> 2);
    rd[k] = !w; wr[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    tick();
    rd[k] = 1'b0; wr[k] = 1'b0;
    addr[k] = $urandom; wdata[k] = $urandom; be[k] = 4'($urandom);
    if (w && inr) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) model[k][wi][8*i +: 8] = d[8*i +: 8];
      end
    end
    if (!w) last_rd[k] = inr ? model[k][wi] : 32'h0;
    for (int e = 1; e <= lat[k]; e++) begin
      if (e > 1) tick();
      chk($sformatf("resp_d%0d_e%0d_a%h", k, e, a), 32'(resp[k]), 32'(e == lat[k]));
      chk($sformatf("busy_d%0d_e%0d", k, e), 32'(busy[k]), 32'd1);
    end
    chk($sformatf("rdata_d%0d_a%h", k, a), rdata[k], last_rd[k]);
    chk($sformatf("aerr_d%0d_a%h", k, a), 32'(aerr[k]), 32'(!inr));
    tick();
    chk($sformatf("resp_end_d%0d", k), 32'(resp[k]), 32'd0);
    chk($sformatf("busy_end_d%0d", k), 32'(busy[k]), 32'd0);
    chk($sformatf("aerr_end_d%0d", k), 32'(aerr[k]), 32'd0);
  endtask

  task automatic rand_txns(input int k, input int n);
    logic [31:0] a;
    for (int j = 0; j < n; j++) begin
      if ($urandom_range(0, 7) == 0) a = 32'(4 * depth[k]) + 32'($urandom_range(0, 5000));
      else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      txn(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
      last_rd[k] = 32'h0;
      for (int i = 0; i < 256; i++) model[k][i] = 32'h0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_resp", 32'(resp[k]), 32'd0);
      chk("rst_busy", 32'(busy[k]), 32'd0);
      chk("rst_aerr", 32'(aerr[k]), 32'd0);
      chk("rst_perr", 32'(perr[k]), 32'd0);
      chk("rst_rdata", rdata[k], 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) txn(k, 1'b1, 32'(i * 4), $urandom, 4'hF);

    txn(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("full_word_rd", rdata[0], 32'hDEADBEEF);
    txn(0, 1'b1, 32'h40, 32'h000000AA, 4'b0001);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("byte0_rd", rdata[0], 32'hDEADBEAA);

    txn(0, 1'b0, 32'h400, 32'h0, 4'h0);
    chk("oor_rdata", rdata[0], 32'h0);
    txn(0, 1'b1, 32'h440, 32'h55555555, 4'hF);
    txn(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("unchanged_rd", rdata[0], 32'hDEADBEAA);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0);

    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h12345678; be[0] = 4'hF;
    repeat (2) begin
      tick();
      chk("conflict_resp", 32'(resp[0]), 32'd0);
      chk("conflict_busy", 32'(busy[0]), 32'd0);
      chk("conflict_perr", 32'(perr[0]), 32'd1);
    end
    rd[0] = 1'b0; wr[0] = 1'b0;
    tick();
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("perr_sticky", 32'(perr[0]), 32'd1);

    txn(0, 1'b1, 32'h80, 32'h11111111, 4'hF);
    wr[0] = 1'b1; addr[0] = 32'h80; wdata[0] = 32'h22222222; be[0] = 4'hF;
    tick();
    chk("abort_busy", 32'(busy[0]), 32'd1);
    wr[0] = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy_rst", 32'(busy[0]), 32'd0);
    chk("abort_perr_rst", 32'(perr[0]), 32'd0);
    chk("abort_rdata_rst", rdata[0], 32'h0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (3) begin
      tick();
      chk("abort_resp", 32'(resp[0]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("abort_resp_post", 32'(resp[0]), 32'd0);
    txn(0, 1'b0, 32'h80, 32'h0, 4'h0);
    chk("abort_keep_rd", rdata[0], 32'h11111111);

    rand_txns(0, 40);

    rd[1] = 1'b1; addr[1] = 32'h0;
    tick();
    chk("b2b_resp1", 32'(resp[1]), 32'd1);
    chk("b2b_data1", rdata[1], model[1][0]);
    addr[1] = 32'h4;
    tick();
    chk("b2b_gap_resp", 32'(resp[1]), 32'd0);
    chk("b2b_gap_busy", 32'(busy[1]), 32'd0);
    tick();
    chk("b2b_resp2", 32'(resp[1]), 32'd1);
    chk("b2b_data2", rdata[1], model[1][1]);
    rd[1] = 1'b0;
    last_rd[1] = model[1][1];
    tick();
    chk("b2b_end_resp", 32'(resp[1]), 32'd0);

    rand_txns(1, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
